// File: rtl/cellrv32_cpu_cp_muldiv_rdx.sv
// Radix-configurable RISC-V "M" co-processor: pipelined array multiplier plus restoring divider.
// Define CELLRV32_MULDIV_FASTDIV_EN to short-cut trivial divisions (zero divisor or |rs1| < |rs2|).
module cellrv32_cpu_cp_muldiv_rdx #(
    parameter int XLEN        = 32,
    parameter int MUL_STAGES  = 1,
    parameter int DIV_BITS    = 1,
    parameter int DIVISION_EN = 1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] res_o,
    output logic            valid_o,
    output logic            busy_o
);
    localparam int DIV_CYC  = XLEN / DIV_BITS;
    localparam int CW       = $clog2(DIV_CYC) + 1;
    localparam int MUL_LOAD = (MUL_STAGES > 0) ? MUL_STAGES - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] op1_q, op2_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic            qneg_q, rneg_q;

    // Operand magnitudes for the divider, taken straight from the inputs at start
    logic            div_signed;
    logic [XLEN-1:0] mag1, mag2;
    logic            fast_div;

    assign div_signed = ~funct3_i[0];
    assign mag1 = (div_signed && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    assign mag2 = (div_signed && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

`ifdef CELLRV32_MULDIV_FASTDIV_EN
    assign fast_div = (DIVISION_EN != 0) && ((rs2_i == '0) || (mag1 < mag2));
`else
    assign fast_div = 1'b0;
`endif

    // Multiplier: (XLEN+1)-bit signed operands so one signed multiply covers all four ops
    logic                     a_sig, b_sig;
    logic signed [XLEN:0]     mul_a, mul_b;
    logic signed [2*XLEN+1:0] prod_full;
    logic [2*XLEN+1:0]        prod_sel;
    logic                     unused_prod;

    assign a_sig     = (funct3_q[1:0] == 2'b01) || (funct3_q[1:0] == 2'b10);
    assign b_sig     = (funct3_q[1:0] == 2'b01);
    assign mul_a     = {a_sig & op1_q[XLEN-1], op1_q};
    assign mul_b     = {b_sig & op2_q[XLEN-1], op2_q};
    assign prod_full = mul_a * mul_b;

    generate
        if (MUL_STAGES == 0) begin : g_mul_comb
            assign prod_sel = prod_full;
        end else begin : g_mul_pipe
            logic [2*XLEN+1:0] pipe_q [MUL_STAGES];
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    for (int i = 0; i < MUL_STAGES; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= prod_full;
                    for (int i = 1; i < MUL_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign prod_sel = pipe_q[MUL_STAGES-1];
        end
    endgenerate

    assign unused_prod = ^prod_sel[2*XLEN+1:2*XLEN];

    // DIV_BITS chained restoring steps; the dividend shifts out of quo_q as quotient bits shift in
    logic [XLEN:0]   trial_r;
    logic            trial_lt;
    logic [XLEN-1:0] step_rem, step_quo;

    always_comb begin
        trial_r  = '0;
        trial_lt = 1'b0;
        step_rem = rem_q;
        step_quo = quo_q;
        for (int i = 0; i < DIV_BITS; i++) begin
            trial_r  = {step_rem, step_quo[XLEN-1]};
            trial_lt = (trial_r < {1'b0, dvs_q});
            step_rem = trial_lt ? trial_r[XLEN-1:0] : XLEN'(trial_r - {1'b0, dvs_q});
            step_quo = {step_quo[XLEN-2:0], ~trial_lt};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        funct3_q <= funct3_i;
                        op1_q    <= rs1_i;
                        op2_q    <= rs2_i;
                        dvs_q    <= mag2;
                        qneg_q   <= (funct3_i == 3'b100) && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1])
                                    && (rs2_i != '0);
                        rneg_q   <= (funct3_i == 3'b110) && rs1_i[XLEN-1];
                        if (!funct3_i[2]) begin
                            cnt_q   <= CW'(MUL_LOAD);
                            state_q <= (MUL_STAGES == 0) ? S_FIN : S_MUL;
                        end else if (fast_div) begin
                            quo_q   <= (rs2_i == '0) ? '1 : '0;
                            rem_q   <= mag1;
                            state_q <= S_FIN;
                        end else begin
                            quo_q   <= mag1;
                            rem_q   <= '0;
                            cnt_q   <= CW'(DIV_CYC - 1);
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (trap_i) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DIV: begin
                    if (trap_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (DIVISION_EN != 0) begin
                            quo_q <= step_quo;
                            rem_q <= step_rem;
                        end
                        if (cnt_q == '0) state_q <= S_FIN;
                        else cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign valid_o = (state_q == S_FIN);
    assign busy_o  = (state_q != S_IDLE);

    // Sign correction of the divider results happens here, on the way out
    always_comb begin
        res_o = '0;
        if (state_q == S_FIN) begin
            case (funct3_q)
                3'b000:                 res_o = prod_sel[XLEN-1:0];
                3'b001, 3'b010, 3'b011: res_o = prod_sel[2*XLEN-1:XLEN];
                3'b100, 3'b101:         res_o = qneg_q ? -quo_q : quo_q;
                default:                res_o = rneg_q ? -rem_q : rem_q;
            endcase
            if (DIVISION_EN == 0 && funct3_q[2]) res_o = '0;
        end
    end
endmodule

// File: tb/tb_cellrv32_cpu_cp_muldiv_rdx.sv
// Self-checking bench for cellrv32_cpu_cp_muldiv_rdx: vector table, corner sequences, random ops vs. arithmetic model.
module tb_cellrv32_cpu_cp_muldiv_rdx;
    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 1;
    localparam int DIV_BITS   = 2;

    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b0;
    logic            start_i = 1'b0;
    logic [2:0]      funct3_i = '0;
    logic            trap_i = 1'b0;
    logic [XLEN-1:0] rs1_i = '0;
    logic [XLEN-1:0] rs2_i = '0;
    logic [XLEN-1:0] res_o;
    logic            valid_o;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    cellrv32_cpu_cp_muldiv_rdx #(
        .XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .DIV_BITS(DIV_BITS), .DIVISION_EN(1)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .funct3_i(funct3_i),
        .trap_i(trap_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .res_o(res_o), .valid_o(valid_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference results straight from the RISC-V M-extension definitions
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua) * 64'(ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (!f3[0] && a[31]) ? (~a + 32'd1) : a;
        mb = (!f3[0] && b[31]) ? (~b + 32'd1) : b;
        if (!f3[2]) return MUL_STAGES + 1;
`ifdef CELLRV32_MULDIV_FASTDIV_EN
        if (b == 0 || ma < mb) return 1;
`endif
        if (ma == mb) return XLEN / DIV_BITS + 1;
        return XLEN / DIV_BITS + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // One operation: start in cycle 0, then watch valid/busy/res each cycle at the falling edge
    task automatic exec(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat,
                        input int trap_cyc, input int restart_cyc, input bit abort);
        logic [31:0] res;
        int          lat;
        bit          busy_bad, zero_bad;
        res = '0; lat = -1; busy_bad = 0; zero_bad = 0;
        @(negedge clk_i);
        funct3_i = f3; rs1_i = a; rs2_i = b; start_i = 1'b1; trap_i = (trap_cyc == 0);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk_i);
            start_i  = (c == restart_cyc);
            trap_i   = (c == trap_cyc);
            funct3_i = 3'($urandom);
            rs1_i    = 32'($urandom);
            rs2_i    = 32'($urandom);
            if (valid_o) begin
                res = res_o; lat = c;
                if (busy_o !== 1'b1) busy_bad = 1;
                break;
            end
            if (res_o !== '0) zero_bad = 1;
            if (abort && c > trap_cyc) begin
                if (busy_o !== 1'b0) busy_bad = 1;
            end else if (busy_o !== 1'b1) begin
                busy_bad = 1;
            end
        end
        start_i = 1'b0; trap_i = 1'b0;
        if (abort) begin
            check({tag, "_novalid"}, 64'(lat), 64'(-1));
        end else begin
            check({tag, "_res"}, 64'(res), 64'(exp_res));
            check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        end
        check({tag, "_busy"}, 64'(busy_bad), 64'(0));
        check({tag, "_reszero"}, 64'(zero_bad), 64'(0));
        @(negedge clk_i);
        check({tag, "_after"}, {61'(res_o), valid_o, busy_o, 1'b0}, 64'(0));
        $display("op %s f3=%0d a=%h b=%h res=%h lat=%0d", tag, f3, a, b, res, lat);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA};
        vecs[2]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd5, 32'd100,       32'h0,         32'hFFFF_FFFF};
        vecs[5]  = '{3'd7, 32'd100,       32'h0,         32'd100};
        vecs[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        vecs[8]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[9]  = '{3'd5, 32'd5,         32'd9,         32'h0};
        vecs[10] = '{3'd7, 32'd5,         32'd9,         32'd5};
        vecs[11] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[12] = '{3'd4, 32'd7,         32'h0,         32'hFFFF_FFFF};
        vecs[13] = '{3'd6, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9};

        // Reset state, during and after reset release
        repeat (3) @(negedge clk_i);
        check("rst_outputs", {61'(res_o), valid_o, busy_o, 1'b0}, 64'(0));
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_outputs", {61'(res_o), valid_o, busy_o, 1'b0}, 64'(0));

        foreach (vecs[i])
            exec($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp,
                 ref_lat(vecs[i].f3, vecs[i].a, vecs[i].b), -1, -1, 1'b0);

        // Trap in cycle 5 of a division aborts it; the next op is unaffected
        exec("trap_div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'h0, 0, 5, -1, 1'b1);
        exec("after_trap", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STAGES + 1, -1, -1, 1'b0);
        // Trap in IDLE (start cycle) and in FIN are ignored
        exec("trap_idle", 3'd0, 32'd6, 32'd7, 32'd42, MUL_STAGES + 1, 0, -1, 1'b0);
        exec("trap_fin", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, MUL_STAGES + 1, MUL_STAGES + 1, -1, 1'b0);
        // Second start while dividing is ignored
        exec("restart", 3'd5, 32'd1000, 32'd7, 32'd142, ref_lat(3'd5, 32'd1000, 32'd7), -1, 3, 1'b0);

        // Asynchronous reset mid-division
        @(negedge clk_i);
        funct3_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("busy_before_rst", 64'(busy_o), 64'(1));
        #1 rstn_i = 1'b0;
        #1 check("async_rst_outputs", {61'(res_o), valid_o, busy_o, 1'b0}, 64'(0));
        @(negedge clk_i);
        rstn_i = 1'b1;
        begin
            bit seen;
            seen = 0;
            repeat (30) begin
                @(negedge clk_i);
                if (valid_o || busy_o) seen = 1;
            end
            check("no_valid_after_rst", 64'(seen), 64'(0));
        end
        $display("op reset_mid_div done");

        // Random operations against the arithmetic model
        for (int n = 0; n < 120; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            exec($sformatf("rnd%0d", n), f3, a, b, ref_res(f3, a, b), ref_lat(f3, a, b), -1, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
